// File: rtl/piezo_melody_sequencer.sv
// Plays fixed vending-event melodies one note at a time on the piezo tone generator.
// Optional macro PIEZO_SEQ_PREEMPT_EN: a valid start while busy restarts with the new melody.
module piezo_melody_sequencer #(
    parameter int TICK_CYCLES = 10000,
    parameter int GAP_CYCLES  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] melody_sel,
    output logic [3:0] note_code,
    output logic       tone_en,
    output logic [2:0] note_played,
    output logic       busy,
    output logic       done
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    mel_q, mel_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    unit_q, unit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_d, enter, start_ok;
    logic [5:0]    cur_entry, next_entry;
    logic [3:0]    cur_units;
    logic [3:0]    code_d;
    logic          tone_d;
    logic [2:0]    played_d;

    function automatic logic [3:0] mel_len(input logic [3:0] sel);
        case (sel)
            4'd1:    mel_len = 4'd2;
            4'd2:    mel_len = 4'd4;
            4'd3:    mel_len = 4'd4;
            4'd4:    mel_len = 4'd3;
            4'd5:    mel_len = 4'd8;
            default: mel_len = 4'd0;
        endcase
    endfunction

    // Entry format {code, dur}; dur encodes 1/2/4/8 duration units.
    function automatic logic [5:0] mel_note(input logic [3:0] sel, input logic [2:0] idx);
        mel_note = 6'd0;
        case (sel)
            4'd1: case (idx)
                3'd0:    mel_note = {4'd5, 2'd0};
                3'd1:    mel_note = {4'd8, 2'd0};
                default: mel_note = 6'd0;
            endcase
            4'd2: case (idx)
                3'd0:    mel_note = {4'd1, 2'd0};
                3'd1:    mel_note = {4'd3, 2'd0};
                3'd2:    mel_note = {4'd5, 2'd0};
                3'd3:    mel_note = {4'd8, 2'd1};
                default: mel_note = 6'd0;
            endcase
            4'd3: case (idx)
                3'd0:    mel_note = {4'd8, 2'd0};
                3'd1:    mel_note = {4'd5, 2'd0};
                3'd2:    mel_note = {4'd3, 2'd0};
                3'd3:    mel_note = {4'd1, 2'd0};
                default: mel_note = 6'd0;
            endcase
            4'd4: case (idx)
                3'd0:    mel_note = {4'd1, 2'd1};
                3'd1:    mel_note = {4'd0, 2'd0};
                3'd2:    mel_note = {4'd1, 2'd1};
                default: mel_note = 6'd0;
            endcase
            4'd5:    mel_note = {({1'b0, idx} + 4'd1), 2'd0};
            default: mel_note = 6'd0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        mel_d    = mel_q;
        idx_d    = idx_q;
        tick_d   = tick_q;
        unit_d   = unit_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        enter    = 1'b0;
        start_ok = start && (mel_len(melody_sel) != 4'd0);

        cur_entry = mel_note(mel_q, idx_q);
        cur_units = 4'd1 << cur_entry[1:0];

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = PLAY;
                    mel_d   = melody_sel;
                    idx_d   = 3'd0;
                    enter   = 1'b1;
                end
            end
            PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (unit_q == cur_units - 4'd1) begin
                        enter = 1'b1;
                        if (({1'b0, idx_q} + 4'd1) == mel_len(mel_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            idx_d = idx_q + 3'd1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        unit_d = unit_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = PLAY;
                    idx_d   = idx_q + 3'd1;
                    enter   = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PIEZO_SEQ_PREEMPT_EN
        if (state_q != IDLE && start_ok) begin
            state_d = PLAY;
            mel_d   = melody_sel;
            idx_d   = 3'd0;
            done_d  = 1'b0;
            enter   = 1'b1;
        end
`endif

        if (enter) begin
            tick_d = '0;
            unit_d = '0;
            gap_d  = '0;
        end

        // Outputs are registered, so they are derived from the upcoming state.
        next_entry = mel_note(mel_d, idx_d);
        code_d     = note_code;
        tone_d     = 1'b0;
        played_d   = note_played;
        case (state_d)
            PLAY: begin
                code_d   = next_entry[5:2];
                tone_d   = (next_entry[5:2] != 4'd0);
                played_d = idx_d;
            end
            GAP:     code_d = note_code;
            default: code_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mel_q       <= 4'd0;
            idx_q       <= 3'd0;
            tick_q      <= '0;
            unit_q      <= 4'd0;
            gap_q       <= '0;
            note_code   <= 4'd0;
            tone_en     <= 1'b0;
            note_played <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mel_q       <= mel_d;
            idx_q       <= idx_d;
            tick_q      <= tick_d;
            unit_q      <= unit_d;
            gap_q       <= gap_d;
            note_code   <= code_d;
            tone_en     <= tone_d;
            note_played <= played_d;
            busy        <= (state_d != IDLE);
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_piezo_melody_sequencer.sv
// Scoreboard bench for piezo_melody_sequencer (TICK_CYCLES=4, GAP_CYCLES=2); honours PIEZO_SEQ_PREEMPT_EN.
module tb_piezo_melody_sequencer;

    localparam int TICK = 4;
    localparam int GAP  = 2;
    localparam int NOLIMIT = 1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] melody_sel;
    logic [3:0] note_code;
    logic       tone_en;
    logic [2:0] note_played;
    logic       busy;
    logic       done;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic       ten;
        logic [2:0] np;
        logic       bsy;
        logic       dn;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   testsRun = 0;
    int   failures = 0;

    piezo_melody_sequencer #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .melody_sel(melody_sel),
        .note_code(note_code), .tone_en(tone_en), .note_played(note_played),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tagName(input int t);
        case (t)
            0: return "reset";
            1: return "invalid_start";
            2: return "melody1";
            3: return "melody2";
            4: return "melody3";
            5: return "melody4";
            6: return "melody5";
            7: return "mid_reset";
            8: return "busy_start";
            default: return "other";
        endcase
    endfunction

    task automatic pushExp(input int c, input int code, input bit ten, input int np,
                           input bit bsy, input bit dn, input int tag, input int limit);
        exp_t e;
        if (c > limit) return;
        e.cyc = c; e.code = 4'(code); e.ten = ten; e.np = 3'(np);
        e.bsy = bsy; e.dn = dn; e.tag = tag;
        sb.push_back(e);
    endtask

    // Hand-written note tables; expands to one expected record per cycle after the start edge.
    task automatic expectMelody(input int c0, input int sel, input int limit,
                                input int trail, input int tag);
        int codes[8];
        int units[8];
        int len;
        int t;
        case (sel)
            1: begin len = 2; codes = '{5,8,0,0,0,0,0,0}; units = '{1,1,0,0,0,0,0,0}; end
            2: begin len = 4; codes = '{1,3,5,8,0,0,0,0}; units = '{1,1,1,2,0,0,0,0}; end
            3: begin len = 4; codes = '{8,5,3,1,0,0,0,0}; units = '{1,1,1,1,0,0,0,0}; end
            4: begin len = 3; codes = '{1,0,1,0,0,0,0,0}; units = '{2,1,2,0,0,0,0,0}; end
            default: begin len = 8; codes = '{1,2,3,4,5,6,7,8}; units = '{1,1,1,1,1,1,1,1}; end
        endcase
        t = c0 + 1;
        for (int k = 0; k < len; k++) begin
            for (int u = 0; u < units[k] * TICK; u++) begin
                pushExp(t, codes[k], codes[k] != 0, k, 1'b1, 1'b0, tag, limit);
                t++;
            end
            if (k < len - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    pushExp(t, codes[k], 1'b0, k, 1'b1, 1'b0, tag, limit);
                    t++;
                end
            end
        end
        pushExp(t, 0, 1'b0, len - 1, 1'b0, 1'b1, tag, limit);
        t++;
        for (int i = 0; i < trail; i++) begin
            pushExp(t, 0, 1'b0, len - 1, 1'b0, 1'b0, tag, limit);
            t++;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        testsRun++;
        if (note_code !== e.code || tone_en !== e.ten || note_played !== e.np ||
            busy !== e.bsy || done !== e.dn) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got code=%0d en=%0b np=%0d busy=%0b done=%0b, want code=%0d en=%0b np=%0d busy=%0b done=%0b",
                     tagName(e.tag), e.cyc, note_code, tone_en, note_played, busy, done,
                     e.code, e.ten, e.np, e.bsy, e.dn);
        end
    endtask

    // Monitor: compares every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checkOutput(sb.pop_front());
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sel);
        start      = 1'b1;
        melody_sel = sel;
        waitCycles(1);
        start      = 1'b0;
    endtask

    initial begin
        int c;
        rst = 1'b1;
        start = 1'b0;
        melody_sel = 4'd0;
        waitCycles(3);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) pushExp(cyc + i, 0, 1'b0, 0, 1'b0, 1'b0, 0, NOLIMIT);
        waitCycles(3);

        c = cyc;
        for (int i = 1; i <= 50; i++) pushExp(c + i, 0, 1'b0, 0, 1'b0, 1'b0, 1, NOLIMIT);
        applyStimulus(4'd0);
        waitCycles(4);
        applyStimulus(4'd9);
        waitCycles(46);

        c = cyc;
        expectMelody(c, 1, c + 11, 0, 2);
        applyStimulus(4'd1);
        waitCycles(10);
        c = cyc;
        expectMelody(c, 5, NOLIMIT, 3, 6);
        applyStimulus(4'd5);
        waitCycles(52);

        c = cyc;
        expectMelody(c, 4, NOLIMIT, 3, 5);
        applyStimulus(4'd4);
        waitCycles(34);

        c = cyc;
        expectMelody(c, 2, c + 13, 0, 7);
        applyStimulus(4'd2);
        waitCycles(12);
        rst = 1'b1;
        pushExp(c + 14, 0, 1'b0, 0, 1'b0, 1'b0, 7, NOLIMIT);
        pushExp(c + 15, 0, 1'b0, 0, 1'b0, 1'b0, 7, NOLIMIT);
        waitCycles(1);
        rst = 1'b0;
        waitCycles(1);
        expectMelody(cyc, 3, NOLIMIT, 3, 4);
        applyStimulus(4'd3);
        waitCycles(30);

        c = cyc;
`ifdef PIEZO_SEQ_PREEMPT_EN
        expectMelody(c, 2, c + 8, 0, 8);
`else
        expectMelody(c, 2, NOLIMIT, 5, 8);
`endif
        applyStimulus(4'd2);
        waitCycles(7);
`ifdef PIEZO_SEQ_PREEMPT_EN
        expectMelody(cyc, 3, NOLIMIT, 5, 8);
`endif
        applyStimulus(4'd3);
        waitCycles(40);

        testsRun++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_expectations got %0d left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
